// File: rtl/flght_seq.sv
`default_nettype none
// ============================================================================
//  Module   : flght_seq
//  Purpose  : Flight sequencer in front of flght_cntrl. Runs the power-up
//             calibration handshake, slew-limits commanded thrust on each
//             inertial reading, and forces a controlled thrust ramp-down on
//             a motors_off command or when the inertial watchdog expires.
//  Ports    : clk, rst_n (async, active low)
//             strt_cal, cal_done, vld, motors_off, thrst_in[8:0]  (inputs)
//             inertial_cal, thrst_out[8:0], mtr_en, cal_err, failsafe
//  Revision : 1.0  initial release
// ============================================================================
module flght_seq #(
    parameter logic [21:0] CAL_TMO  = 22'd2_000_000,
    parameter logic [16:0] WDOG_CYC = 17'd100_000,
    parameter logic [7:0]  RAMP_DIV = 8'd64,
    parameter int unsigned SLEW     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strt_cal,
    input  logic       cal_done,
    input  logic       vld,
    input  logic       motors_off,
    input  logic [8:0] thrst_in,
    output logic       inertial_cal,
    output logic [8:0] thrst_out,
    output logic       mtr_en,
    output logic       cal_err,
    output logic       failsafe
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAL     = 2'd1,
        S_RUN     = 2'd2,
        S_RAMP_DN = 2'd3
    } state_t;

    localparam logic signed [9:0] c_slew_pos = 10'(SLEW);
    localparam logic signed [9:0] c_slew_neg = -c_slew_pos;
    localparam logic [8:0]        c_slew_u9  = 9'(SLEW);

    state_t      r_state, w_state_nxt;
    logic        r_inertial_cal, w_inertial_cal;
    logic        r_mtr_en, w_mtr_en;
    logic [8:0]  r_thrst, w_thrst;
    logic        r_cal_err, w_cal_err;
    logic        r_failsafe, w_failsafe;
    logic [21:0] r_tmr, w_tmr;
    logic [16:0] r_wdog, w_wdog;
    logic [7:0]  r_rdiv, w_rdiv;
    logic        w_expire;

    // Slew limiter: difference taken at 10 bits signed so that a request
    // below the current value never wraps. When within one slew step the
    // output lands exactly on the request, so it can never overshoot.
    logic signed [9:0] w_diff;
    logic [8:0]        w_slewed;

    always_comb begin
        w_diff = $signed({1'b0, thrst_in}) - $signed({1'b0, r_thrst});
        if (w_diff > c_slew_pos)
            w_slewed = r_thrst + c_slew_u9;
        else if (w_diff < c_slew_neg)
            w_slewed = r_thrst - c_slew_u9;
        else
            w_slewed = thrst_in;
    end

    // Next-state and next-output logic; every register value is computed
    // here so all outputs change on the edge that enters a state.
    always_comb begin
        w_state_nxt    = r_state;
        w_inertial_cal = r_inertial_cal;
        w_mtr_en       = r_mtr_en;
        w_thrst        = r_thrst;
        w_cal_err      = r_cal_err;
        w_failsafe     = r_failsafe;
        w_tmr          = r_tmr;
        w_wdog         = r_wdog;
        w_rdiv         = r_rdiv;
        w_expire       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_inertial_cal = 1'b0;
                w_mtr_en       = 1'b0;
                w_thrst        = 9'd0;
                if (strt_cal) begin
                    w_state_nxt    = S_CAL;
                    w_inertial_cal = 1'b1;
                    w_mtr_en       = 1'b1;
                    w_tmr          = 22'd0;
                    w_cal_err      = 1'b0;
                    w_failsafe     = 1'b0;
                end
            end

            S_CAL: begin
                w_tmr = r_tmr + 22'd1;
                // Priority: motors_off, then cal_done, then timeout.
                if (motors_off) begin
                    w_state_nxt    = S_IDLE;
                    w_inertial_cal = 1'b0;
                    w_mtr_en       = 1'b0;
                end else if (cal_done) begin
                    w_state_nxt    = S_RUN;
                    w_inertial_cal = 1'b0;
                    w_thrst        = 9'd0;
                    w_wdog         = 17'd0;
                end else if (r_tmr == CAL_TMO - 22'd1) begin
                    w_state_nxt    = S_IDLE;
                    w_cal_err      = 1'b1;
                    w_inertial_cal = 1'b0;
                    w_mtr_en       = 1'b0;
                end
            end

            S_RUN: begin
                w_wdog   = r_wdog + 17'd1;
                w_expire = !vld && (r_wdog == WDOG_CYC - 17'd1);
                if (motors_off || w_expire) begin
                    // Thrust freezes at its current value and ramps from there.
                    w_state_nxt = S_RAMP_DN;
                    w_rdiv      = 8'd0;
                    if (w_expire)
                        w_failsafe = 1'b1;
                end else if (vld) begin
                    w_thrst = w_slewed;
                    w_wdog  = 17'd0;
                end
            end

            S_RAMP_DN: begin
                if (r_thrst == 9'd0) begin
                    w_state_nxt = S_IDLE;
                    w_mtr_en    = 1'b0;
                end else if (r_rdiv == RAMP_DIV - 8'd1) begin
                    w_rdiv  = 8'd0;
                    w_thrst = r_thrst - 9'd1;
                end else begin
                    w_rdiv = r_rdiv + 8'd1;
                end
            end

            default: begin
                w_state_nxt    = S_IDLE;
                w_inertial_cal = 1'b0;
                w_mtr_en       = 1'b0;
                w_thrst        = 9'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_inertial_cal <= 1'b0;
            r_mtr_en       <= 1'b0;
            r_thrst        <= 9'd0;
            r_cal_err      <= 1'b0;
            r_failsafe     <= 1'b0;
            r_tmr          <= 22'd0;
            r_wdog         <= 17'd0;
            r_rdiv         <= 8'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_inertial_cal <= w_inertial_cal;
            r_mtr_en       <= w_mtr_en;
            r_thrst        <= w_thrst;
            r_cal_err      <= w_cal_err;
            r_failsafe     <= w_failsafe;
            r_tmr          <= w_tmr;
            r_wdog         <= w_wdog;
            r_rdiv         <= w_rdiv;
        end
    end

    assign inertial_cal = r_inertial_cal;
    assign thrst_out    = r_thrst;
    assign mtr_en       = r_mtr_en;
    assign cal_err      = r_cal_err;
    assign failsafe     = r_failsafe;

endmodule
`default_nettype wire

// File: tb/tb_flght_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flght_seq
//  Purpose  : Self-checking bench for flght_seq with shortened timeouts.
//             A mode-level reference model predicts every output each cycle;
//             directed checks cover the calibration, slew, watchdog,
//             ramp-down and asynchronous reset scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_flght_seq;

    localparam int T_CAL  = 1000;
    localparam int T_WDOG = 500;
    localparam int T_RDIV = 64;
    localparam int T_SLEW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       strt_cal, cal_done, vld, motors_off;
    logic [8:0] thrst_in;
    logic       inertial_cal, mtr_en, cal_err, failsafe;
    logic [8:0] thrst_out;

    flght_seq #(
        .CAL_TMO  (22'(T_CAL)),
        .WDOG_CYC (17'(T_WDOG)),
        .RAMP_DIV (8'(T_RDIV)),
        .SLEW     (T_SLEW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .strt_cal     (strt_cal),
        .cal_done     (cal_done),
        .vld          (vld),
        .motors_off   (motors_off),
        .thrst_in     (thrst_in),
        .inertial_cal (inertial_cal),
        .thrst_out    (thrst_out),
        .mtr_en       (mtr_en),
        .cal_err      (cal_err),
        .failsafe     (failsafe)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0=idle 1=calibrating 2=running 3=ramping down
    int m_mode, m_thr, m_cal_cycles, m_quiet, m_ramp_cycles;
    bit m_cal_err, m_fs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_thr = 0; m_cal_cycles = 0; m_quiet = 0; m_ramp_cycles = 0;
        m_cal_err = 0; m_fs = 0;
    endtask

    // Predicts the effect of the coming clock edge from the present inputs.
    task automatic model_step();
        int  d;
        bit  expire;
        case (m_mode)
            0: begin
                m_thr = 0;
                if (strt_cal) begin
                    m_mode = 1; m_cal_cycles = 0; m_cal_err = 0; m_fs = 0;
                end
            end
            1: begin
                if (motors_off) m_mode = 0;
                else if (cal_done) begin m_mode = 2; m_thr = 0; m_quiet = 0; end
                else if (m_cal_cycles + 1 >= T_CAL) begin m_mode = 0; m_cal_err = 1; end
                else m_cal_cycles++;
            end
            2: begin
                expire = !vld && (m_quiet + 1 >= T_WDOG);
                if (motors_off || expire) begin
                    m_mode = 3; m_ramp_cycles = 0;
                    if (expire) m_fs = 1;
                end else if (vld) begin
                    d = int'(thrst_in) - m_thr;
                    if (d > T_SLEW)  d = T_SLEW;
                    if (d < -T_SLEW) d = -T_SLEW;
                    m_thr   = m_thr + d;
                    m_quiet = 0;
                end else m_quiet++;
            end
            default: begin
                if (m_thr == 0) m_mode = 0;
                else begin
                    m_ramp_cycles++;
                    if (m_ramp_cycles == T_RDIV) begin m_thr--; m_ramp_cycles = 0; end
                end
            end
        endcase
    endtask

    task automatic cyc();
        logic [12:0] exp_v;
        model_step();
        @(posedge clk);
        #1;
        exp_v = {(m_mode == 1), (m_mode != 0), m_cal_err, m_fs, 9'(m_thr)};
        check("cycle_outputs", {19'd0, inertial_cal, mtr_en, cal_err, failsafe, thrst_out},
              {19'd0, exp_v});
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic pulse_strt();
        strt_cal = 1'b1; cyc(); strt_cal = 1'b0;
    endtask

    task automatic pulse_cal_done();
        cal_done = 1'b1; cyc(); cal_done = 1'b0;
    endtask

    task automatic pulse_vld(input int gap);
        vld = 1'b1; cyc(); vld = 1'b0;
        idle_cycles(gap);
    endtask

    initial begin
        rst_n = 1'b0; strt_cal = 1'b0; cal_done = 1'b0; vld = 1'b0;
        motors_off = 1'b0; thrst_in = 9'd0;
        model_reset();
        #2;
        check("rst_inertial_cal", 32'(inertial_cal), 32'd0);
        check("rst_mtr_en",       32'(mtr_en),       32'd0);
        check("rst_thrst_out",    32'(thrst_out),    32'd0);
        check("rst_flags",        32'({cal_err, failsafe}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(3);

        // Calibration handshake
        pulse_strt();
        check("cal_inertial_cal", 32'(inertial_cal), 32'd1);
        check("cal_mtr_en",       32'(mtr_en),       32'd1);
        idle_cycles(99);
        pulse_cal_done();
        check("run_inertial_cal", 32'(inertial_cal), 32'd0);
        check("run_mtr_en",       32'(mtr_en),       32'd1);
        check("run_thrst0",       32'(thrst_out),    32'd0);

        // Slew up to 10 then down to 0
        thrst_in = 9'd10;
        pulse_vld(49); check("slew_up_4",  32'(thrst_out), 32'd4);
        pulse_vld(49); check("slew_up_8",  32'(thrst_out), 32'd8);
        pulse_vld(49); check("slew_up_10", 32'(thrst_out), 32'd10);
        pulse_vld(49); check("slew_hold",  32'(thrst_out), 32'd10);
        thrst_in = 9'd0;
        pulse_vld(49); check("slew_dn_6",  32'(thrst_out), 32'd6);
        pulse_vld(49); check("slew_dn_2",  32'(thrst_out), 32'd2);
        pulse_vld(49); check("slew_dn_0",  32'(thrst_out), 32'd0);

        // strt_cal while running is ignored
        pulse_strt();
        check("run_strt_ignored", 32'({inertial_cal, mtr_en}), 32'b01);

        // Randomized running phase; stray strt_cal/cal_done must be ignored
        for (int i = 0; i < 800; i++) begin
            vld      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) thrst_in = 9'($urandom_range(0, 511));
            strt_cal = ($urandom_range(0, 31) == 0);
            cal_done = ($urandom_range(0, 31) == 0);
            cyc();
        end
        vld = 1'b0; strt_cal = 1'b0; cal_done = 1'b0;

        // Settle at thrust 3, then let the watchdog expire
        thrst_in = 9'd3;
        for (int i = 0; i < 300 && m_thr != 3; i++) pulse_vld(1);
        pulse_vld(0);
        check("wd_start_thrst", 32'(thrst_out), 32'd3);
        idle_cycles(T_WDOG - 1);
        check("wd_not_yet", 32'({mtr_en, failsafe}), 32'b10);
        cyc();
        check("wd_failsafe", 32'({mtr_en, failsafe}), 32'b11);
        thrst_in = 9'd200; vld = 1'b1;      // ignored while ramping
        idle_cycles(T_RDIV - 1);
        vld = 1'b0;
        check("ramp_hold_3", 32'(thrst_out), 32'd3);
        cyc();                         check("ramp_2", 32'(thrst_out), 32'd2);
        idle_cycles(T_RDIV);           check("ramp_1", 32'(thrst_out), 32'd1);
        idle_cycles(T_RDIV);           check("ramp_0", 32'(thrst_out), 32'd0);
        check("ramp_0_mtr_en", 32'(mtr_en), 32'd1);
        cyc();
        check("ramp_done_mtr_en", 32'(mtr_en), 32'd0);

        // Calibration timeout, then strt_cal clears the sticky flags
        pulse_strt();
        check("tmo_flags_clear", 32'({cal_err, failsafe}), 32'd0);
        idle_cycles(T_CAL - 1);
        check("tmo_not_yet", 32'({inertial_cal, mtr_en, cal_err}), 32'b110);
        cyc();
        check("tmo_cal_err", 32'({inertial_cal, mtr_en, cal_err}), 32'b001);
        pulse_strt();
        check("tmo_err_cleared", 32'({inertial_cal, cal_err}), 32'b10);

        // motors_off beats cal_done in CAL
        motors_off = 1'b1; cal_done = 1'b1; cyc(); motors_off = 1'b0; cal_done = 1'b0;
        check("cal_moff_wins", 32'({inertial_cal, mtr_en, cal_err}), 32'b000);
        idle_cycles(2);

        // motors_off in RUN at zero thrust: one ramp cycle then idle
        pulse_strt(); idle_cycles(5); pulse_cal_done();
        thrst_in = 9'd0;
        motors_off = 1'b1; cyc(); motors_off = 1'b0;
        check("moff_ramp", 32'({mtr_en, failsafe}), 32'b10);
        cyc();
        check("moff_idle", 32'(mtr_en), 32'd0);

        // Asynchronous reset while ramping from 100
        pulse_strt(); pulse_cal_done();
        thrst_in = 9'd100;
        for (int i = 0; i < 60 && m_thr != 100; i++) pulse_vld(1);
        motors_off = 1'b1; cyc(); motors_off = 1'b0;
        idle_cycles(10);
        check("pre_rst_thrst", 32'(thrst_out), 32'd100);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_outputs", 32'({inertial_cal, mtr_en, cal_err, failsafe, thrst_out}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flght_seq.md
Name: flght_seq

Overview:
Sequencer that sits in front of flght_cntrl.
- Drives flght_cntrl's inertial_cal and thrst inputs.
- Drives the ESC-side motor enable.
- Runs the power-up calibration handshake with the inertial interface.
- Slew-limits commanded thrust.
- Forces a controlled ramp-down on a motors_off command or loss of vld (inertial watchdog).

Parameters:
CAL_TMO, 22'd2_000_000, max cycles in CAL waiting for cal_done (tmr width 22)
WDOG_CYC, 17'd100_000, max cycles between vld pulses while RUN
RAMP_DIV, 8'd64, cycles per 1-LSB thrust decrement in RAMP_DN
SLEW, 4, max thrust change per vld in RUN (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
strt_cal  in  1  1-cycle pulse from cmd_cfg: begin calibration
cal_done  in  1  1-cycle pulse from inertial interface: calibration complete
vld  in  1  new inertial reading valid (same pulse as flght_cntrl vld)
motors_off  in  1  1-cycle pulse from cmd_cfg: shut motors down
thrst_in  in  9  requested thrust, unsigned, from cmd_cfg
inertial_cal  out  1  to flght_cntrl and inertial interface; high only in CAL
thrst_out  out  9  slew-limited thrust to flght_cntrl
mtr_en  out  1  high in CAL, RUN, RAMP_DN
cal_err  out  1  sticky: calibration timed out
failsafe  out  1  sticky: ramp-down caused by watchdog

Behaviour:
- All outputs are registered. On rst_n low (asynchronous):
  - state=IDLE
  - inertial_cal=0, mtr_en=0, thrst_out=0, cal_err=0, failsafe=0
  - tmr=0, wdog=0, rdiv=0
- Reset mid-operation has the same effect from any state; no ramp-down occurs.
- Outputs change on the clock edge that enters a state; that is, they are visible 1 cycle after the causing input.
- States: IDLE, CAL, RUN, RAMP_DN.
- IDLE:
  - mtr_en=0, thrst_out=0.
  - strt_cal -> CAL: inertial_cal=1, mtr_en=1, tmr=0, cal_err=0, failsafe=0.
  - All other inputs are ignored.
- CAL:
  - tmr increments every cycle.
  - cal_done -> RUN: inertial_cal=0, thrst_out=0, wdog=0.
  - tmr==CAL_TMO-1 without cal_done -> IDLE: cal_err=1, inertial_cal=0, mtr_en=0.
  - cal_done and timeout in the same cycle: cal_done wins.
  - motors_off -> IDLE immediately; cal_err unchanged.
  - motors_off and cal_done in the same cycle: motors_off wins.
  - strt_cal is ignored.
- RUN:
  - wdog increments every cycle and clears on vld.
  - On vld, thrst_out steps toward thrst_in by min(SLEW, |thrst_in-thrst_out|).
    - Compute the difference at 10 bits signed so there is no wrap.
    - thrst_out never overshoots thrst_in and stays within 0..511.
  - Without vld, thrst_out holds.
  - wdog==WDOG_CYC-1 with no vld -> RAMP_DN, failsafe=1.
  - motors_off -> RAMP_DN, failsafe unchanged.
  - motors_off and watchdog expiry in the same cycle: RAMP_DN with failsafe=1.
  - strt_cal is ignored.
- RAMP_DN:
  - rdiv counts 0..RAMP_DIV-1.
  - At each wrap, thrst_out decrements by 1 (floor 0).
  - Entering with thrst_out==0, or reaching 0 -> IDLE on the next cycle, mtr_en=0.
  - vld, thrst_in and strt_cal are ignored; there is no return to RUN.
  - motors_off is ignored because the block is already ramping.
- cal_err and failsafe clear only on strt_cal accepted in IDLE, or on reset.
- thrst_in is sampled only on vld in RUN. Changes at other times have no effect.

Test Plan:
1. Reset, then strt_cal, then cal_done 100 cycles later -> inertial_cal=1 and mtr_en=1 from cycle+1 after strt_cal; inertial_cal=0 and state RUN 1 cycle after cal_done; thrst_out=0.
2. In RUN with thrst_in=9'd10, SLEW=4, vld every 50 cycles -> thrst_out goes 4, 8, 10, then holds. Then thrst_in=9'd0 -> thrst_out goes 6, 2, 0.
3. strt_cal with no cal_done, CAL_TMO overridden to 1000 -> at cycle 1000 cal_err=1, mtr_en=0, state IDLE. A following strt_cal clears cal_err.
4. In RUN at thrst_out=9'd3, stop vld, WDOG_CYC=500 -> RAMP_DN with failsafe=1 after 500 cycles. thrst_out reaches 2, 1, 0 at RAMP_DIV intervals (64 cycles each), then mtr_en=0 one cycle later.
5. motors_off in RUN at thrst_out=9'd0 -> RAMP_DN then IDLE on the next cycle, failsafe=0. Also assert motors_off and cal_done in the same cycle in CAL -> IDLE, no cal_err.
6. rst_n asserted asynchronously mid-RAMP_DN (thrst_out=9'd100) -> all outputs 0 immediately without a clock edge. Also assert strt_cal during RUN -> no state change.
